// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - period/high-time monitor with lock, mismatch and stall detection
module clk_ratio_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             mismatch_o,
  output logic             stall_o,
  output logic [7:0]       err_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_TRACK  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

  logic [1:0]       state;
  logic             sig_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] ref_period;
  logic [CNT_W-1:0] ref_high;
  logic [3:0]       match;

  logic       rise;
  logic       meas;
  logic       same;
  logic       timeout;
  logic [3:0] match_inc;
  logic [7:0] err_inc;

  assign rise      = sig_i & ~sig_q;
  assign meas      = rise && (state != S_IDLE);
  assign same      = (cnt == ref_period) && (hcnt == ref_high);
  assign timeout   = (state != S_IDLE) && (cnt == TIMEOUT_C) && !rise;
  assign match_inc = match + 4'd1;
  assign err_inc   = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;
  assign locked_o  = (state == S_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sig_q        <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      ref_period   <= '0;
      ref_high     <= '0;
      match        <= 4'd0;
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
      mismatch_o   <= 1'b0;
      stall_o      <= 1'b0;
      err_cnt_o    <= 8'd0;
    end else begin
      sig_q        <= sig_i;
      meas_valid_o <= meas;
      mismatch_o   <= 1'b0;
      stall_o      <= 1'b0;

      // A rise in IDLE still starts the count so the first armed period is exact
      if (rise)
        cnt <= CNT_ONE;
      else if (timeout || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CNT_ONE;

      if (rise)
        hcnt <= CNT_ONE;
      else if (sig_i && hcnt != CNT_MAX)
        hcnt <= hcnt + CNT_ONE;

      if (meas) begin
        period_o <= cnt;
        high_o   <= hcnt;
      end

      case (state)
        S_IDLE: begin
          if (rise)
            state <= S_ARMED;
        end
        S_ARMED: begin
          if (meas) begin
            ref_period <= cnt;
            ref_high   <= hcnt;
            match      <= 4'd1;
            state      <= (LOCK_CNT == 1) ? S_LOCKED : S_TRACK;
          end
        end
        S_TRACK: begin
          if (meas) begin
            if (same) begin
              match <= match_inc;
              if (match_inc >= LOCK_C)
                state <= S_LOCKED;
            end else begin
              ref_period <= cnt;
              ref_high   <= hcnt;
              match      <= 4'd1;
            end
          end
        end
        default: begin
          if (meas && !same) begin
            mismatch_o <= 1'b1;
            err_cnt_o  <= err_inc;
            ref_period <= cnt;
            ref_high   <= hcnt;
            match      <= 4'd1;
            state      <= S_TRACK;
          end
        end
      endcase

      // Timeout excludes a rise, so it never collides with a measurement above
      if (timeout) begin
        state   <= S_IDLE;
        stall_o <= 1'b1;
        if (state == S_LOCKED)
          err_cnt_o <= err_inc;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - randomized scoreboard bench for clk_ratio_monitor
module tb_clk_ratio_monitor;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_i = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid_o;
  logic             locked_o;
  logic             mismatch_o;
  logic             stall_o;
  logic [7:0]       err_cnt_o;

  clk_ratio_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sig_i(sig_i),
    .period_o(period_o), .high_o(high_o), .meas_valid_o(meas_valid_o),
    .locked_o(locked_o), .mismatch_o(mismatch_o), .stall_o(stall_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit stall;
    int p;
    int h;
    bit mm;
    bit lk;
    int err;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  t      = 0;

  // Reference model state: timestamps of rises and a count of identical measurements
  bit m_prev, m_active, m_have_ref, m_locked;
  int m_last, m_high, m_ref_p, m_ref_h, m_run, m_err;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_prev = 0; m_active = 0; m_have_ref = 0; m_locked = 0;
    m_last = 0; m_high = 0; m_ref_p = 0; m_ref_h = 0; m_run = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit s);
    ev_t e;
    bit  r;
    r = s && !m_prev;
    if (r) begin
      if (m_active) begin
        e.cyc = t; e.stall = 0; e.p = t - m_last; e.h = m_high; e.mm = 0;
        if (!m_have_ref || e.p != m_ref_p || e.h != m_ref_h) begin
          if (m_locked) begin
            e.mm  = 1;
            m_err = (m_err < 255) ? m_err + 1 : 255;
          end
          m_have_ref = 1; m_ref_p = e.p; m_ref_h = e.h;
          m_run = 1;
          m_locked = (LOCK_CNT == 1);
        end else if (!m_locked) begin
          m_run++;
          if (m_run >= LOCK_CNT) m_locked = 1;
        end
        e.lk = m_locked; e.err = m_err;
        q.push_back(e);
      end
      m_active = 1; m_last = t; m_high = 1;
    end else begin
      if (s && m_high < 255) m_high++;
      if (m_active && (t - m_last) == TIMEOUT) begin
        if (m_locked) m_err = (m_err < 255) ? m_err + 1 : 255;
        e.cyc = t; e.stall = 1; e.p = 0; e.h = 0; e.mm = 0; e.lk = 0; e.err = m_err;
        q.push_back(e);
        m_active = 0; m_have_ref = 0; m_locked = 0; m_run = 0;
      end
    end
    m_prev = s;
  endfunction

  task automatic step(bit s);
    sig_i = s;
    model_step(s);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic sq(int p, int h, int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        step(i < h);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    sig_i = 1'b0;
    @(posedge clk);
    #1;
    t++;
    rst = 1'b0;
    model_reset();
    chk("rst_period", int'(period_o), 0);
    chk("rst_high", int'(high_o), 0);
    chk("rst_meas_valid", int'(meas_valid_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_mismatch", int'(mismatch_o), 0);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_err_cnt", int'(err_cnt_o), 0);
    chk("rst_queue_empty", q.size(), 0);
    q.delete();
  endtask

  // Monitor: pops an expected event whenever one is due or the DUT pulses
  always @(negedge clk) begin
    ev_t e;
    bit  due;
    while (q.size() > 0 && q[0].cyc < t - 1) begin
      e = q.pop_front();
      chk(e.stall ? "missed_stall" : "missed_meas", 0, 1);
    end
    due = (q.size() > 0) && (q[0].cyc == t - 1);
    if (due || meas_valid_o === 1'b1 || stall_o === 1'b1 || mismatch_o === 1'b1) begin
      if (!due) begin
        chk("unexpected_pulse", int'({meas_valid_o, stall_o, mismatch_o}), 0);
      end else begin
        e = q.pop_front();
        chk("meas_valid", int'(meas_valid_o), int'(!e.stall));
        chk("stall", int'(stall_o), int'(e.stall));
        chk("mismatch", int'(mismatch_o), int'(e.mm));
        chk("locked", int'(locked_o), int'(e.lk));
        chk("err_cnt", int'(err_cnt_o), e.err);
        if (!e.stall) begin
          chk("period", int'(period_o), e.p);
          chk("high", int'(high_o), e.h);
        end
      end
    end
  end

  initial begin
    int p, h, n;
    model_reset();
    do_reset();

    sq(2, 1, 12);
    do_reset();
    sq(16, 8, 8);
    sq(4, 2, 8);
    sq(8, 4, 8);
    sq(8, 2, 8);

    sq(4, 2, 6);
    repeat (300) step(1'b0);
    sq(255, 1, 5);
    sq(4, 2, 6);
    repeat (300) step(1'b1);
    step(1'b0);

    sq(3, 1, 8);
    do_reset();
    sq(3, 1, 6);

    for (int k = 0; k < 265; k++) begin
      sq(2, 1, 5);
      sq(3, 1, 1);
    end

    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(2, 20));
      h = int'($urandom_range(1, p - 1));
      n = int'($urandom_range(1, 7));
      sq(p, h, n);
      if ($urandom_range(0, 9) == 0) repeat (260) step(1'b0);
      if ($urandom_range(0, 14) == 0) repeat (260) step(1'b1);
    end

    repeat (4) step(1'b0);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
